// File: rtl/preg_alloc_ctrl_if.sv
// Rename-allocation / commit-return / free-list signal bundle for preg_alloc_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline's view.
interface preg_alloc_ctrl_if #(
  parameter int PREG_BITS  = 6,
  parameter int NLANE      = 2,
  parameter int DEPTH_BITS = 5
);
  logic                            alloc_valid;
  logic [NLANE-1:0]                alloc_req;
  logic                            alloc_ready;
  logic [NLANE-1:0][PREG_BITS-1:0] alloc_preg;
  logic [NLANE-1:0]                ret_valid;
  logic [NLANE-1:0][PREG_BITS-1:0] ret_preg;
  logic                            rob_flush;
  logic [NLANE-1:0][PREG_BITS-1:0] fl_dout;
  logic [DEPTH_BITS:0]             fl_elemcount;
  logic [NLANE-1:0]                fl_dequeue;
  logic [NLANE-1:0]                fl_enqueue;
  logic [NLANE-1:0][PREG_BITS-1:0] fl_din;
  logic                            fl_flush;
  logic [15:0]                     stall_cnt;

  modport slave (
    input  alloc_valid, alloc_req, ret_valid, ret_preg, rob_flush, fl_dout, fl_elemcount,
    output alloc_ready, alloc_preg, fl_dequeue, fl_enqueue, fl_din, fl_flush, stall_cnt
  );

  modport master (
    output alloc_valid, alloc_req, ret_valid, ret_preg, rob_flush, fl_dout, fl_elemcount,
    input  alloc_ready, alloc_preg, fl_dequeue, fl_enqueue, fl_din, fl_flush, stall_cnt
  );
endinterface

// File: rtl/preg_alloc_ctrl.sv
// Physical-register allocation controller: all-or-nothing multi-lane grants from a
// free list, registered commit returns, and a fixed allocation blackout after flush.
module preg_alloc_ctrl #(
  parameter int PREG_BITS    = 6,
  parameter int NLANE        = 2,
  parameter int DEPTH_BITS   = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  preg_alloc_ctrl_if.slave  bus
);
  localparam int NEED_W = $clog2(NLANE) + 1;
  localparam int EC_W   = DEPTH_BITS + 1;
  localparam int CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t                          r_state, w_state_nxt;
  logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
  logic [NEED_W-1:0]               w_need, w_ret_cnt, r_ret_cnt;
  logic [NEED_W-1:0]               w_req_rank [NLANE];
  logic [NEED_W-1:0]               w_ret_rank [NLANE];
  logic [NLANE-1:0][PREG_BITS-1:0] w_ret_pack, r_ret_data;
  logic                            w_ready, w_fire, w_stage_clr;
  logic [15:0]                     r_stall;

  // Rank of each lane = number of active lanes below it; the running sum ends as popcount.
  always_comb begin
    w_need    = '0;
    w_ret_cnt = '0;
    for (int unsigned i = 0; i < NLANE; i++) begin
      w_req_rank[i] = w_need;
      w_ret_rank[i] = w_ret_cnt;
      w_need        = w_need + NEED_W'(bus.alloc_req[i]);
      w_ret_cnt     = w_ret_cnt + NEED_W'(bus.ret_valid[i]);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NLANE; i++) begin
      bus.alloc_preg[i] = '0;
      w_ret_pack[i]     = '0;
    end
    for (int unsigned i = 0; i < NLANE; i++) begin
      for (int unsigned j = 0; j < NLANE; j++) begin
        if (bus.alloc_req[i] && (w_req_rank[i] == NEED_W'(j)))
          bus.alloc_preg[i] = bus.fl_dout[j];
        if (bus.ret_valid[i] && (w_ret_rank[i] == NEED_W'(j)))
          w_ret_pack[j] = bus.ret_preg[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A flush arriving mid-blackout reloads the counter, restarting the blackout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_ready = !bus.rob_flush && (EC_W'(w_need) <= bus.fl_elemcount);
        if (bus.rob_flush) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (bus.rob_flush)
          w_cnt_nxt = CNT_LOAD;
        else if (r_cnt == '0)
          w_state_nxt = ST_RUN;
        else
          w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_fire          = bus.alloc_valid && w_ready;
    w_stage_clr     = bus.rob_flush || (r_state == ST_FLUSH);
    bus.alloc_ready = w_ready;
    bus.fl_flush    = bus.rob_flush;
    bus.fl_din      = r_ret_data;
    bus.stall_cnt   = r_stall;
    for (int unsigned j = 0; j < NLANE; j++) begin
      bus.fl_dequeue[j] = w_fire && (NEED_W'(j) < w_need);
      bus.fl_enqueue[j] = NEED_W'(j) < r_ret_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_cnt  <= '0;
      r_ret_data <= '0;
      r_stall    <= '0;
    end else begin
      if (w_stage_clr) begin
        r_ret_cnt  <= '0;
        r_ret_data <= '0;
      end else begin
        r_ret_cnt  <= w_ret_cnt;
        r_ret_data <= w_ret_pack;
      end
      if (bus.alloc_valid && !w_ready && (r_stall != '1))
        r_stall <= r_stall + 16'd1;
    end
  end
endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Scoreboard bench for preg_alloc_ctrl: a cycle-level reference model pushes expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_preg_alloc_ctrl;
  localparam int PB = 6;
  localparam int NL = 2;
  localparam int DB = 5;
  localparam int FC = 2;

  typedef struct {
    logic              ready;
    logic [NL-1:0][PB-1:0] preg;
    logic [NL-1:0]     deq;
    logic [NL-1:0]     enq;
    logic [NL-1:0][PB-1:0] din;
    logic              flush;
    logic [15:0]       stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  exp_t exp_q[$];
  int   m_pend[$];
  int   m_flush_left = 0;
  int   m_stall = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  preg_alloc_ctrl_if #(.PREG_BITS(PB), .NLANE(NL), .DEPTH_BITS(DB)) bus ();

  preg_alloc_ctrl #(.PREG_BITS(PB), .NLANE(NL), .DEPTH_BITS(DB), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, expv);
    end
  endtask

  // One clock of stimulus; the model computes what the DUT must show during this cycle.
  task automatic drive(input logic v, input logic [NL-1:0] req, input logic [NL-1:0][PB-1:0] dout,
                       input int elem, input logic [NL-1:0] rv, input logic [NL-1:0][PB-1:0] rp,
                       input logic fl, input logic r);
    exp_t e;
    int   need, k;
    logic fire, in_fl;
    @(posedge clk);
    #1;
    rst              = r;
    bus.alloc_valid  = v;
    bus.alloc_req    = req;
    bus.fl_dout      = dout;
    bus.fl_elemcount = (DB+1)'(elem);
    bus.ret_valid    = rv;
    bus.ret_preg     = rp;
    bus.rob_flush    = fl;
    if (r) begin
      m_flush_left = 0;
      m_pend.delete();
      m_stall = 0;
      return;
    end
    need    = $countones(req);
    in_fl   = m_flush_left > 0;
    e.ready = !in_fl && !fl && (need <= elem);
    fire    = v && e.ready;
    k = 0;
    for (int i = 0; i < NL; i++) begin
      e.preg[i] = '0;
      if (req[i]) begin
        e.preg[i] = dout[k];
        k++;
      end
    end
    e.deq   = fire ? NL'((1 << need) - 1) : '0;
    e.enq   = NL'((1 << m_pend.size()) - 1);
    for (int j = 0; j < NL; j++)
      e.din[j] = (j < m_pend.size()) ? PB'(m_pend[j]) : '0;
    e.flush = fl;
    e.stall = 16'(m_stall);
    exp_q.push_back(e);
    if (v && !e.ready && m_stall < 65535) m_stall++;
    m_pend.delete();
    if (!fl && !in_fl)
      for (int i = 0; i < NL; i++)
        if (rv[i]) m_pend.push_back(int'(rp[i]));
    if (fl) m_flush_left = FC;
    else if (m_flush_left > 0) m_flush_left--;
  endtask

  task automatic idle(input int elem);
    drive(1'b0, '0, '0, elem, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 32, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 32, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("alloc_ready", 32'(bus.alloc_ready), 32'(e.ready));
        chk("alloc_preg",  32'(bus.alloc_preg),  32'(e.preg));
        chk("fl_dequeue",  32'(bus.fl_dequeue),  32'(e.deq));
        chk("fl_enqueue",  32'(bus.fl_enqueue),  32'(e.enq));
        chk("fl_din",      32'(bus.fl_din),      32'(e.din));
        chk("fl_flush",    32'(bus.fl_flush),    32'(e.flush));
        chk("stall_cnt",   32'(bus.stall_cnt),   32'(e.stall));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [NL-1:0][PB-1:0] d, p;
    bus.alloc_valid = 1'b0; bus.alloc_req = '0; bus.fl_dout = '0; bus.fl_elemcount = '0;
    bus.ret_valid = '0; bus.ret_preg = '0; bus.rob_flush = 1'b0;
    do_reset();
    idle(32);

    // single upper-lane request compacts to the free-list head
    d = {6'd9, 6'd7};
    drive(1'b1, 2'b10, d, 32, '0, '0, 1'b0, 1'b0);
    d = {6'd21, 6'd12};
    drive(1'b1, 2'b11, d, 2, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 2'b11, d, 1, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, d, 0, '0, '0, 1'b0, 1'b0);

    // upper-lane return lands in enqueue slot 0 next cycle
    p = {6'd40, 6'd3};
    drive(1'b0, '0, '0, 32, 2'b10, p, 1'b0, 1'b0);
    idle(32);
    idle(32);

    // three stall cycles
    do_reset();
    d = {6'd5, 6'd6};
    repeat (3) drive(1'b1, 2'b11, d, 1, '0, '0, 1'b0, 1'b0);
    idle(1);

    // flush with concurrent returns, then blackout
    p = {6'd33, 6'd34};
    drive(1'b1, 2'b01, d, 32, 2'b11, p, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 2'b01, d, 32, 2'b11, p, 1'b0, 1'b0);
    idle(32);

    // back-to-back flush extends the blackout
    drive(1'b1, 2'b01, d, 32, '0, '0, 1'b1, 1'b0);
    drive(1'b1, 2'b01, d, 32, '0, '0, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 2'b01, d, 32, '0, '0, 1'b0, 1'b0);

    // reset in the middle of a blackout with a nonzero stall count
    do_reset();
    repeat (5) drive(1'b1, 2'b01, d, 0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, d, 32, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, d, 32, '0, '0, 1'b1, 1'b1);
    drive(1'b1, 2'b11, d, 32, '0, '0, 1'b0, 1'b0);
    idle(32);

    for (int n = 0; n < 600; n++) begin
      int el;
      el = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 32));
      drive($urandom_range(0, 3) != 0, NL'($urandom), (NL*PB)'($urandom), el,
            NL'($urandom), (NL*PB)'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 79) == 0);
    end
    idle(32);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/preg_alloc_ctrl.md
PREG_ALLOC_CTRL -- requirements
Module: preg_alloc_ctrl

Interface
REQ-001 SHALL have parameter PREG_BITS, default 6, physical register index width.
REQ-002 SHALL have parameter NLANE, default 2, rename/commit lanes per cycle.
REQ-003 SHALL have parameter DEPTH_BITS, default 5, free-list depth log2.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 2, allocation blackout length after flush.
REQ-005 SHALL have: clk  input  1  clock; rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have: alloc_valid  input  1  rename group valid.
REQ-007 SHALL have: alloc_req  input  NLANE  per-lane destination needs preg (rd != x0).
REQ-008 SHALL have: alloc_ready  output  1  group can be granted this cycle.
REQ-009 SHALL have: alloc_preg  output  NLANE x PREG_BITS  granted preg per lane.
REQ-010 SHALL have: ret_valid  input  NLANE; ret_preg  input  NLANE x PREG_BITS  commit-freed old pregs.
REQ-011 SHALL have: rob_flush  input  1  pipeline flush request.
REQ-012 SHALL have: fl_dout  input  NLANE x PREG_BITS; fl_elemcount  input  DEPTH_BITS+1  free-list head data and occupancy.
REQ-013 SHALL have: fl_dequeue  output  NLANE; fl_enqueue  output  NLANE; fl_din  output  NLANE x PREG_BITS; fl_flush  output  1  free-list controls.
REQ-014 SHALL have: stall_cnt  output  16  saturating count of cycles alloc_valid=1 and alloc_ready=0.

Function
REQ-015 SHALL implement FSM states RUN and FLUSH; reset state RUN.
REQ-016 SHALL compute need = popcount(alloc_req), width clog2(NLANE)+1, zero-extended to DEPTH_BITS+1 for compare.
REQ-017 SHALL drive alloc_ready = (state==RUN) and not rob_flush and (need <= fl_elemcount); all-or-nothing, no partial grant.
REQ-018 SHALL define fire = alloc_valid and alloc_ready; alloc_ready SHALL not depend on alloc_valid.
REQ-019 SHALL set fl_dequeue thermometer-coded: bits [need-1:0] set when fire, else all zero.
REQ-020 SHALL compact grants: lane i with alloc_req[i]=1 gets fl_dout[k], k = count of alloc_req bits below i; lanes with alloc_req[i]=0 get alloc_preg[i]=0.
REQ-021 SHALL drive alloc_preg combinationally regardless of fire (zero latency, valid only when fire).
REQ-022 SHALL register the return path one cycle: stage holds compacted pregs and count = popcount(ret_valid).
REQ-023 SHALL drive fl_enqueue thermometer [cnt-1:0] and fl_din[j] = j-th compacted return from the registered stage.
REQ-024 SHALL, on rob_flush in RUN: assert fl_flush that same cycle, clear return stage (next cycle fl_enqueue=0), enter FLUSH with counter = FLUSH_CYCLES-1.
REQ-025 SHALL in FLUSH: alloc_ready=0, fl_dequeue=0, ret_valid ignored (not captured), counter decrements; at counter 0 return to RUN next cycle.
REQ-026 SHALL treat rob_flush during FLUSH as restart: fl_flush=1, counter reloaded, return stage kept clear.
REQ-027 SHALL assert fl_flush only for the cycle rob_flush is high; rob_flush priority over fire and returns.
REQ-028 SHALL increment stall_cnt by 1 per stall cycle, holding at 16'hFFFF.
REQ-029 SHALL never drive fl_dequeue and fl_flush high in the same cycle.

Reset
REQ-030 SHALL on rst: state=RUN, flush counter=0, return stage count=0 and data=0, stall_cnt=0.
REQ-031 SHALL after rst: fl_enqueue=0, fl_flush=0, fl_dequeue=0 until a fire; rst overrides rob_flush and mid-FLUSH state.

Verification
REQ-032 SHALL cover: elemcount=32, alloc_valid=1, alloc_req=2'b10, fl_dout={7,9} -> alloc_ready=1, alloc_preg[1]=7, alloc_preg[0]=0, fl_dequeue=2'b01.
REQ-033 SHALL cover: elemcount=1, alloc_req=2'b11, alloc_valid=1 for 3 cycles -> alloc_ready=0, fl_dequeue=0, stall_cnt=3.
REQ-034 SHALL cover: ret_valid=2'b10, ret_preg[1]=40 at cycle t -> cycle t+1 fl_enqueue=2'b01, fl_din[0]=40.
REQ-035 SHALL cover: ret_valid=2'b11 at cycle t with rob_flush=1 at t -> fl_flush=1 at t, fl_enqueue=0 at t+1, alloc_ready=0 for t..t+2, ready at t+3 (FLUSH_CYCLES=2).
REQ-036 SHALL cover: rob_flush at t and t+1 -> FLUSH extended, alloc_ready first high at t+4.
REQ-037 SHALL cover: rst asserted while in FLUSH with stall_cnt=5 -> next cycle state RUN, stall_cnt=0, alloc_ready=1 given elemcount>=need.
